jesd204_lmfc_gen: RTL and testbench

//  Next-generation LMFC/LMC timing generator for JESD204 TX/RX link layers (8B/10B and 64B/66B).

---
 rtl/jesd204_lmfc_gen_pkg.sv | 22 ++
 rtl/jesd204_lmfc_gen_sysref_sync.sv | 32 +++
 rtl/jesd204_lmfc_gen.sv | 179 +++++++++++++++++
 tb/tb_jesd204_lmfc_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jesd204_lmfc_gen_pkg.sv
// Shared SYSREF mode and LMFC state encodings for the LMFC/LMC timing generator.
package jesd204_lmfc_gen_pkg;

  typedef enum logic [1:0] {
    MODE_CONT    = 2'd0,
    MODE_ONESHOT = 2'd1,
    MODE_DIS     = 2'd2,
    MODE_MON     = 2'd3
  } sysref_mode_t;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_ALIGNED = 2'd1,
    ST_HOLD    = 2'd2
  } lmfc_state_t;

  // LMFC doubling only exists for 8B/10B links with an 8-octet data path.
  function automatic logic double_allowed(input int link_mode, input int dpw);
    return (link_mode == 1) && (dpw == 8);
  endfunction

endpackage

// File: rtl/jesd204_lmfc_gen_sysref_sync.sv
// SYSREF capture: input register, metastability chain, registered rising-edge detect.
module jesd204_sysref_sync #(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic sysref,
  input  logic sysref_disable,
  output logic sysref_edge
);

  logic                   sysref_in_r;
  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_last_d;

  // Sample and synchronise SYSREF; left out of reset so an in-flight pulse survives a link reset
  always_ff @(posedge clk) begin
    sysref_in_r <= sysref;
    sync_chain  <= {sync_chain[SYNC_STAGES-2:0], sysref_in_r};
    sync_last_d <= sync_chain[SYNC_STAGES-1];
  end

  // One-cycle rising-edge pulse, suppressed entirely when SYSREF is disabled
  always_ff @(posedge clk) begin
    if (reset) begin
      sysref_edge <= 1'b0;
    end else begin
      sysref_edge <= !sysref_disable && sync_chain[SYNC_STAGES-1] && !sync_last_d;
    end
  end

endmodule

// File: rtl/jesd204_lmfc_gen.sv
// LMFC/LMC timing generator: SYSREF-aligned beat counter, alignment FSM,
// phase/misalignment monitoring and registered LMFC/LMC/EoEMB strobes.
module jesd204_lmfc_gen
  import jesd204_lmfc_gen_pkg::*;
#(
  parameter int LINK_MODE       = 1,
  parameter int DATA_PATH_WIDTH = 4,
  parameter int CNT_WIDTH       = 10,
  parameter int SYNC_STAGES     = 3,
  parameter int ERR_CNT_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sysref,
  input  logic [CNT_WIDTH-1:0]     cfg_beats_per_multiframe,
  input  logic                     cfg_lmfc_double,
  input  logic [CNT_WIDTH-1:0]     cfg_lmfc_offset,
  input  logic [1:0]               cfg_sysref_mode,
  input  logic                     sysref_rearm,
  input  logic                     err_clear,
  output logic [CNT_WIDTH-1:0]     lmfc_counter,
  output logic                     lmfc_edge,
  output logic                     lmc_edge,
  output logic                     lmc_quarter_edge,
  output logic                     eoemb,
  output logic                     lmfc_clk,
  output logic                     sysref_edge,
  output logic                     sysref_alignment_error,
  output logic [CNT_WIDTH-1:0]     sysref_phase,
  output logic                     sysref_phase_valid,
  output logic [ERR_CNT_WIDTH-1:0] sysref_error_count,
  output logic [1:0]               lmfc_state
);

  localparam logic DOUBLE_OK = double_allowed(LINK_MODE, DATA_PATH_WIDTH);

  sysref_mode_t         mode;
  lmfc_state_t          state;
  logic                 rearm_pending;
  logic [CNT_WIDTH:0]   last;
  logic [CNT_WIDTH:0]   half;
  logic                 cnt_at_last;
  logic                 cnt_at_half;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 active;
  logic                 align;
  logic                 monitored;
  logic                 phase_err;
  logic                 p1;

  assign mode       = sysref_mode_t'(cfg_sysref_mode);
  assign lmfc_state = state;

  jesd204_sysref_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sysref_sync (
    .clk           (clk),
    .reset         (reset),
    .sysref        (sysref),
    .sysref_disable(mode == MODE_DIS),
    .sysref_edge   (sysref_edge)
  );

  // Last beat index (one bit wider so 2*cfg+1 cannot overflow) and free-running successor
  always_comb begin
    last = (cfg_lmfc_double && DOUBLE_OK) ? {cfg_beats_per_multiframe, 1'b1}
                                          : {1'b0, cfg_beats_per_multiframe};
    half        = last >> 1;
    cnt_at_last = ({1'b0, lmfc_counter} == last);
    cnt_at_half = ({1'b0, lmfc_counter} == half);
    cnt_next    = cnt_at_last ? '0 : lmfc_counter + 1'b1;
  end

  // Decide whether the current synchronised edge realigns the counter and whether it is checked
  always_comb begin
    active = (state != ST_WAIT);
    align  = 1'b0;
    unique case (mode)
      MODE_CONT:    align = sysref_edge;
      MODE_ONESHOT: align = sysref_edge &&
                            ((state == ST_WAIT) || ((state == ST_HOLD) && rearm_pending));
      MODE_MON:     align = sysref_edge && (state == ST_WAIT);
      MODE_DIS:     align = 1'b0;
    endcase
    monitored = sysref_edge && active;
    phase_err = monitored && (cnt_next != cfg_lmfc_offset);
  end

  // Alignment FSM; oneshot parks in HOLD and only realigns on the edge after a rearm
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= (mode == MODE_DIS) ? ST_ALIGNED : ST_WAIT;
      rearm_pending <= 1'b0;
    end else begin
      unique case (state)
        ST_WAIT:    if (align) state <= ST_ALIGNED;
        ST_ALIGNED: if (mode == MODE_ONESHOT) state <= ST_HOLD;
        ST_HOLD:    state <= ST_HOLD;
        default:    state <= ST_WAIT;
      endcase
      if ((mode == MODE_ONESHOT) && (state == ST_HOLD)) begin
        if (sysref_rearm) begin
          rearm_pending <= 1'b1;
        end else if (align) begin
          rearm_pending <= 1'b0;
        end
      end else begin
        rearm_pending <= 1'b0;
      end
    end
  end

  // Beat counter: always runs, loads the offset on an aligning edge
  always_ff @(posedge clk) begin
    if (reset) begin
      lmfc_counter <= CNT_WIDTH'(1);
    end else if (align) begin
      lmfc_counter <= cfg_lmfc_offset;
    end else begin
      lmfc_counter <= cnt_next;
    end
  end

  // Phase capture and saturating misalignment count; the comparison uses the pre-load successor
  always_ff @(posedge clk) begin
    if (reset) begin
      sysref_alignment_error <= 1'b0;
      sysref_phase           <= '0;
      sysref_phase_valid     <= 1'b0;
      sysref_error_count     <= '0;
    end else begin
      sysref_alignment_error <= phase_err;
      if (monitored) begin
        sysref_phase       <= cnt_next;
        sysref_phase_valid <= 1'b1;
      end
      if (phase_err) begin
        if (err_clear) begin
          sysref_error_count <= ERR_CNT_WIDTH'(1);
        end else if (sysref_error_count != '1) begin
          sysref_error_count <= sysref_error_count + 1'b1;
        end
      end else if (err_clear) begin
        sysref_error_count <= '0;
      end
    end
  end

  // Timing strobes, one cycle behind the counter value and gated until alignment
  always_ff @(posedge clk) begin
    if (reset) begin
      lmfc_edge        <= 1'b0;
      lmc_edge         <= 1'b0;
      lmc_quarter_edge <= 1'b0;
      eoemb            <= 1'b0;
    end else begin
      lmfc_edge        <= active && (lmfc_counter == '0);
      lmc_edge         <= active && (lmfc_counter[4:0] == '0);
      lmc_quarter_edge <= active && (lmfc_counter[2:0] == '0);
      eoemb            <= active && (lmfc_counter[CNT_WIDTH-1:5] == last[CNT_WIDTH-1:5]);
    end
  end

  // LMFC-rate waveform: high from the wrap to the half-frame point, output delayed one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      p1       <= 1'b0;
      lmfc_clk <= 1'b0;
    end else begin
      if (cnt_at_last) begin
        p1 <= 1'b1;
      end else if (cnt_at_half) begin
        p1 <= 1'b0;
      end
      lmfc_clk <= p1;
    end
  end

endmodule

// File: tb/tb_jesd204_lmfc_gen.sv
// Scoreboard bench for jesd204_lmfc_gen: a modulo-arithmetic reference model predicts
// every output per cycle; a separate monitor pops and compares.
module tb_jesd204_lmfc_gen;

  localparam int CW = 10;
  localparam int EW = 8;
  localparam int S  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sysref = 1'b0;
  logic [CW-1:0] cfg_beats_per_multiframe = '0;
  logic          cfg_lmfc_double = 1'b0;
  logic [CW-1:0] cfg_lmfc_offset = '0;
  logic [1:0]    cfg_sysref_mode = '0;
  logic          sysref_rearm = 1'b0;
  logic          err_clear = 1'b0;
  logic [CW-1:0] lmfc_counter;
  logic          lmfc_edge, lmc_edge, lmc_quarter_edge, eoemb, lmfc_clk;
  logic          sysref_edge, sysref_alignment_error, sysref_phase_valid;
  logic [CW-1:0] sysref_phase;
  logic [EW-1:0] sysref_error_count;
  logic [1:0]    lmfc_state;

  always #5 clk = ~clk;

  jesd204_lmfc_gen #(
    .LINK_MODE(1), .DATA_PATH_WIDTH(8), .CNT_WIDTH(CW),
    .SYNC_STAGES(S), .ERR_CNT_WIDTH(EW)
  ) dut (
    .clk(clk), .reset(reset), .sysref(sysref),
    .cfg_beats_per_multiframe(cfg_beats_per_multiframe),
    .cfg_lmfc_double(cfg_lmfc_double), .cfg_lmfc_offset(cfg_lmfc_offset),
    .cfg_sysref_mode(cfg_sysref_mode), .sysref_rearm(sysref_rearm),
    .err_clear(err_clear), .lmfc_counter(lmfc_counter), .lmfc_edge(lmfc_edge),
    .lmc_edge(lmc_edge), .lmc_quarter_edge(lmc_quarter_edge), .eoemb(eoemb),
    .lmfc_clk(lmfc_clk), .sysref_edge(sysref_edge),
    .sysref_alignment_error(sysref_alignment_error), .sysref_phase(sysref_phase),
    .sysref_phase_valid(sysref_phase_valid), .sysref_error_count(sysref_error_count),
    .lmfc_state(lmfc_state)
  );

  typedef struct {
    int cnt; int le; int lc; int lq; int eo; int lclk;
    int se; int ae; int ph; int pv; int ec; int st;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: counter is anchor value plus elapsed cycles modulo frame length
  int m_mode = 0, m_last = 15, m_off = 0;
  int m_av = 1, m_ac = 0, cyc = 0;
  int m_st = 0, m_armed = 0, m_ph = 0, m_pv = 0, m_ec = 0;
  int m_p1 = 0, m_lclk = 0, m_edge = 0, m_le = 0, m_lc = 0, m_lq = 0, m_eo = 0, m_ae = 0;
  bit [7:0] m_hist = '0;

  function automatic int m_cnt(input int at);
    return (m_av + at - m_ac) % (m_last + 1);
  endfunction

  // True when the edge presented this cycle will be reported as misaligned
  function automatic bit m_err_now();
    return (m_edge != 0) && (m_st != 0) && (((m_cnt(cyc) + 1) % (m_last + 1)) != m_off);
  endfunction

  task automatic model_step(input bit sr, input bit rearm, input bit clr, input bit rst);
    int c, nxt, old_st;
    bit act, mon, al, err;
    m_hist = {m_hist[6:0], sr};
    if (rst) begin
      m_av = 1; m_ac = cyc + 1;
      m_le = 0; m_lc = 0; m_lq = 0; m_eo = 0; m_ae = 0;
      m_ph = 0; m_pv = 0; m_ec = 0; m_p1 = 0; m_lclk = 0; m_edge = 0;
      m_st = (m_mode == 2) ? 1 : 0;
      m_armed = 0;
    end else begin
      c      = m_cnt(cyc);
      act    = (m_st != 0);
      nxt    = (c + 1) % (m_last + 1);
      mon    = (m_edge != 0) && act;
      old_st = m_st;
      case (m_mode)
        0:       al = (m_edge != 0);
        1:       al = (m_edge != 0) && (m_st == 0 || (m_st == 2 && m_armed != 0));
        3:       al = (m_edge != 0) && (m_st == 0);
        default: al = 1'b0;
      endcase
      err  = mon && (nxt != m_off);
      m_le = (act && c == 0) ? 1 : 0;
      m_lc = (act && c % 32 == 0) ? 1 : 0;
      m_lq = (act && c % 8 == 0) ? 1 : 0;
      m_eo = (act && ((c >> 5) % 32) == ((m_last >> 5) % 32)) ? 1 : 0;
      m_lclk = m_p1;
      if (c == m_last) m_p1 = 1;
      else if (c == m_last / 2) m_p1 = 0;
      m_ae = err ? 1 : 0;
      if (mon) begin
        m_ph = nxt;
        m_pv = 1;
      end
      if (err) m_ec = clr ? 1 : ((m_ec == 255) ? 255 : m_ec + 1);
      else if (clr) m_ec = 0;
      if (old_st == 0 && al) m_st = 1;
      else if (old_st == 1 && m_mode == 1) m_st = 2;
      m_armed = (old_st == 2 && m_mode == 1) ? (rearm ? 1 : (al ? 0 : m_armed)) : 0;
      if (al) begin
        m_av = m_off;
        m_ac = cyc + 1;
      end
      m_edge = (m_mode != 2 && m_hist[S+1] && !m_hist[S+2]) ? 1 : 0;
    end
    cyc++;
  endtask

  task automatic tick(input bit sr, input bit rearm, input bit clr, input bit rst);
    exp_t e;
    sysref = sr; sysref_rearm = rearm; err_clear = clr; reset = rst;
    model_step(sr, rearm, clr, rst);
    e.cnt = m_cnt(cyc); e.le = m_le; e.lc = m_lc; e.lq = m_lq; e.eo = m_eo;
    e.lclk = m_lclk; e.se = m_edge; e.ae = m_ae; e.ph = m_ph; e.pv = m_pv;
    e.ec = m_ec; e.st = m_st;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input int mode, input int cfg, input bit dbl, input int off);
    cfg_sysref_mode          = 2'(mode);
    cfg_beats_per_multiframe = CW'(cfg);
    cfg_lmfc_double          = dbl;
    cfg_lmfc_offset          = CW'(off);
    m_mode = mode;
    m_last = dbl ? 2 * cfg + 1 : cfg;
    m_off  = off;
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // SYSREF pulses of the given width and period; optional coincident err_clear on errors
  task automatic train(input int period, input int nedges, input int width, input bit clr_on_err);
    for (int e = 0; e < nedges; e++) begin
      for (int i = 0; i < period; i++) begin
        tick(i < width, 1'b0, clr_on_err && m_err_now(), 1'b0);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at t=%0t actual %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected record per clock, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("lmfc_counter", int'(lmfc_counter), e.cnt);
        chk("lmfc_edge", int'(lmfc_edge), e.le);
        chk("lmc_edge", int'(lmc_edge), e.lc);
        chk("lmc_quarter_edge", int'(lmc_quarter_edge), e.lq);
        chk("eoemb", int'(eoemb), e.eo);
        chk("lmfc_clk", int'(lmfc_clk), e.lclk);
        chk("sysref_edge", int'(sysref_edge), e.se);
        chk("alignment_error", int'(sysref_alignment_error), e.ae);
        chk("sysref_phase", int'(sysref_phase), e.ph);
        chk("phase_valid", int'(sysref_phase_valid), e.pv);
        chk("error_count", int'(sysref_error_count), e.ec);
        chk("lmfc_state", int'(lmfc_state), e.st);
      end
    end
  end

  initial begin
    int mode, cfg, off, per, l;
    bit dbl;
    repeat (6) tick(1'b0, 1'b0, 1'b0, 1'b1);

    // Continuous mode, period a multiple of the frame
    configure(0, 15, 1'b0, 3);
    train(64, 8, 2, 1'b0);

    // Continuous mode, period off by one, run long enough to saturate the counter
    configure(0, 15, 1'b0, 0);
    train(65, 300, 3, 1'b0);

    // Oneshot: lock, shift phase by 5, then rearm
    configure(1, 31, 1'b0, 7);
    train(64, 3, 2, 1'b0);
    repeat (5) tick(1'b0, 1'b0, 1'b0, 1'b0);
    train(64, 3, 2, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    train(64, 4, 2, 1'b0);

    // Disabled and monitor modes
    configure(2, 15, 1'b0, 2);
    train(20, 5, 4, 1'b0);
    configure(3, 15, 1'b0, 5);
    train(65, 5, 1, 1'b0);

    // Doubled frame, and a wide frame for eoemb/lmc_edge
    configure(0, 7, 1'b1, 0);
    train(64, 4, 2, 1'b0);
    configure(0, 255, 1'b0, 10);
    train(256, 3, 2, 1'b0);

    // err_clear coincident with errors, then reset mid-frame with SYSREF in flight
    configure(0, 15, 1'b0, 4);
    train(65, 4, 2, 1'b1);
    repeat (7) tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    train(64, 3, 2, 1'b0);

    // Randomised configurations and periods
    for (int it = 0; it < 14; it++) begin
      mode = $urandom_range(0, 3);
      cfg  = $urandom_range(3, 63);
      dbl  = 1'($urandom_range(0, 1));
      l    = (dbl ? 2 * cfg + 1 : cfg) + 1;
      off  = $urandom_range(0, cfg);
      per  = ($urandom_range(0, 1) != 0) ? l * $urandom_range(1, 2) : $urandom_range(8, 200);
      if (per < 8) per = l * 8;
      configure(mode, cfg, dbl, off);
      for (int e = 0; e < 6; e++) begin
        for (int i = 0; i < per; i++) begin
          tick(i < 2, ($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), 1'b0);
        end
      end
    end

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
